// File: rtl/mem_bist_pkg.sv
// ============================================================================
// Module  : mem_bist_pkg
// Brief   : Shared state encoding, default geometry and pattern generator
//           for the memory BIST host.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bist_pkg;

    localparam int DEF_ADDR_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_RD0  = 3'd2,
        ST_DR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RD1  = 3'd5,
        ST_DR1  = 3'd6,
        ST_DONE = 3'd7
    } bist_state_e;

    // Second pass uses the bitwise complement so every cell sees both polarities.
    function automatic logic [7:0] bist_pattern(input logic [7:0] seed,
                                                input logic [3:0] a_lo,
                                                input logic       inv);
        logic [7:0] p;
        p = seed ^ {a_lo, a_lo};
        return inv ? ~p : p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bist_chk.sv
// ============================================================================
// Module  : mem_bist_chk
// Brief   : Read-data compare, first-failure capture and mismatch counter.
//           Counter present only when MEM_BIST_ERRCNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bist_chk #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 vld_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           exp_i,
    input  logic [7:0]           rdata_i,
    output logic                 pass_o,
    output logic [ADDR_BITS-1:0] fail_addr_o,
    output logic [7:0]           fail_data_o,
    output logic [4:0]           err_cnt_o
);

    logic                 pass_q;
    logic [ADDR_BITS-1:0] fail_addr_q;
    logic [7:0]           fail_data_q;
    logic                 mism;

    assign mism = vld_i && (rdata_i != exp_i);

    // pass_q still high means no mismatch has been captured this run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (clr_i) begin
            pass_q      <= 1'b1;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (mism && pass_q) begin
            pass_q      <= 1'b0;
            fail_addr_q <= addr_i;
            fail_data_q <= rdata_i;
        end
    end

`ifdef MEM_BIST_ERRCNT_EN
    logic [4:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end else if (mism && (err_cnt_q != 5'd31)) begin
            err_cnt_q <= err_cnt_q + 5'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

endmodule

`default_nettype wire

// File: rtl/mem_bist_host.sv
// ============================================================================
// Module  : mem_bist_host
// Brief   : Two-pass write/read memory BIST sequencer with pipelined compare.
//           Optional mismatch counter: define MEM_BIST_ERRCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bist_host
    import mem_bist_pkg::*;
#(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           seed,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_wr_en,
    output logic                 mem_r_en,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [7:0]           fail_data,
    output logic [4:0]           err_cnt
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_BYTES - 1);

    bist_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           seed_q;
    logic                 cmp_vld_q;
    logic [ADDR_BITS-1:0] cmp_addr_q;
    logic [7:0]           cmp_exp_q;

    logic                 start_ok;
    logic                 phase1;
    logic                 at_last;
    logic [3:0]           addr_lo;
    logic [7:0]           pat;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign phase1   = (state_q == ST_WR1) || (state_q == ST_RD1);
    assign at_last  = (addr_q == LAST_ADDR);
    assign addr_lo  = 4'(addr_q);
    assign pat      = bist_pattern(seed_q, addr_lo, phase1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            seed_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            cmp_exp_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (start_ok) begin
                seed_q <= seed;
            end
            // Read data returns one cycle after the strobe, so the expected
            // value and address are delayed to line up with it.
            cmp_vld_q  <= (state_q == ST_RD0) || (state_q == ST_RD1);
            cmp_addr_q <= addr_q;
            cmp_exp_q  <= pat;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_r_en  = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = ST_WR0;
                end
            end
            ST_WR0, ST_WR1: begin
                mem_wr_en = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = pat;
                if (at_last) begin
                    state_d = (state_q == ST_WR0) ? ST_RD0 : ST_RD1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_RD0, ST_RD1: begin
                mem_r_en = 1'b1;
                mem_addr = addr_q;
                if (at_last) begin
                    state_d = (state_q == ST_RD0) ? ST_DR0 : ST_DR1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DR0: begin
                state_d = ST_WR1;
                addr_d  = '0;
            end
            ST_DR1: begin
                state_d = ST_DONE;
                addr_d  = '0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    mem_bist_chk #(
        .ADDR_BITS (ADDR_BITS)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_ok),
        .vld_i       (cmp_vld_q),
        .addr_i      (cmp_addr_q),
        .exp_i       (cmp_exp_q),
        .rdata_i     (mem_rdata),
        .pass_o      (pass),
        .fail_addr_o (fail_addr),
        .fail_data_o (fail_data),
        .err_cnt_o   (err_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_bist_host.sv
// ============================================================================
// Module  : tb_mem_bist_host
// Brief   : Self-checking bench for mem_bist_host with a faultable 16x8 memory
//           and a pass-level reference model. Honours MEM_BIST_ERRCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bist_host;

    localparam int RAM_BYTES  = 16;
    localparam int DONE_DELAY = 4 * RAM_BYTES + 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [3:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_r_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic [4:0] err_cnt;

    logic [7:0] mem   [RAM_BYTES];
    logic [7:0] f_and [RAM_BYTES];
    logic [7:0] f_or  [RAM_BYTES];

    int n_cmp = 0;
    int n_err = 0;
    int wr_total = 0;
    int rd_total = 0;
    int overlap  = 0;

    mem_bist_host #(
        .RAM_BYTES (RAM_BYTES),
        .ADDR_BITS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_r_en  (mem_r_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with per-address read fault: rdata = (cell & f_and) | f_or.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            wr_total      <= wr_total + 1;
        end
        if (mem_r_en) begin
            mem_rdata <= (mem[mem_addr] & f_and[mem_addr]) | f_or[mem_addr];
            rd_total  <= rd_total + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en && mem_r_en) begin
            overlap <= overlap + 1;
        end
        assert (!(mem_wr_en && mem_r_en))
            else $error("FAIL strobe_overlap: wr_en and r_en both high");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < RAM_BYTES; i++) begin
            f_and[i] = 8'hFF;
            f_or[i]  = 8'h00;
        end
    endtask

    // Walks both passes over every address and applies the read fault.
    task automatic model(input logic [7:0] sd, output logic ep, output logic [3:0] ea,
                         output logic [7:0] ed, output logic [4:0] ec);
        int         n;
        logic [7:0] e;
        logic [7:0] g;
        logic [3:0] a4;
        n  = 0;
        ep = 1'b1;
        ea = '0;
        ed = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < RAM_BYTES; a++) begin
                a4 = 4'(a);
                e  = sd ^ {a4, a4};
                if (ph == 1) e = ~e;
                g = (e & f_and[a]) | f_or[a];
                if (g != e) begin
                    if (ep) begin
                        ep = 1'b0;
                        ea = a4;
                        ed = g;
                    end
                    n++;
                end
            end
        end
`ifdef MEM_BIST_ERRCNT_EN
        ec = (n > 31) ? 5'd31 : 5'(n);
`else
        ec = 5'd0;
`endif
    endtask

    task automatic run_bist(input string name, input logic [7:0] sd,
                            input bit poke, input int rst_at);
        logic       ep;
        logic [3:0] ea;
        logic [7:0] ed;
        logic [4:0] ec;
        bit         got;
        int         wr0, rd0;
        model(sd, ep, ea, ed, ec);
        wr0   = wr_total;
        rd0   = rd_total;
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seed  = 8'($urandom);
        got   = 1'b0;
        for (int k = 1; k <= DONE_DELAY + 14 && !got; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check_eq({name, ".busy"}, 32'(busy), 32'd1);
            if (poke && k == 20) start = 1'b1;
            if (poke && k == 21) start = 1'b0;
            if (rst_at == k) begin
                check_eq({name, ".wr1_wr_en"}, 32'(mem_wr_en), 32'd1);
                rst_n = 1'b0;
                #1;
                check_eq({name, ".rst_wr_en"}, 32'(mem_wr_en), 32'd0);
                check_eq({name, ".rst_r_en"},  32'(mem_r_en),  32'd0);
                check_eq({name, ".rst_busy"},  32'(busy),      32'd0);
                check_eq({name, ".rst_pass"},  32'(pass),      32'd0);
                check_eq({name, ".rst_addr"},  32'(mem_addr),  32'd0);
                check_eq({name, ".rst_wdata"}, 32'(mem_wdata), 32'd0);
                check_eq({name, ".rst_done"},  32'(done),      32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                got = 1'b1;
                check_eq({name, ".done_cycle"}, 32'(k), 32'(DONE_DELAY));
            end
        end
        if (!got) begin
            check_eq({name, ".done_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({name, ".pass"},      32'(pass),    32'(ep));
        check_eq({name, ".fail_addr"}, 32'(fail_addr), 32'(ea));
        check_eq({name, ".fail_data"}, 32'(fail_data), 32'(ed));
        check_eq({name, ".err_cnt"},   32'(err_cnt), 32'(ec));
        check_eq({name, ".writes"},    32'(wr_total - wr0), 32'(2 * RAM_BYTES));
        check_eq({name, ".reads"},     32'(rd_total - rd0), 32'(2 * RAM_BYTES));
        @(posedge clk);
        #1;
        check_eq({name, ".done_pulse"}, 32'(done), 32'd0);
        check_eq({name, ".idle"},       32'(busy), 32'd0);
        check_eq({name, ".pass_hold"},  32'(pass), 32'(ep));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        seed  = 8'h00;
        clear_faults();
        #2;
        check_eq("reset.busy",      32'(busy),      32'd0);
        check_eq("reset.done",      32'(done),      32'd0);
        check_eq("reset.pass",      32'(pass),      32'd0);
        check_eq("reset.strobes",   32'({mem_wr_en, mem_r_en}), 32'd0);
        check_eq("reset.fail_addr", 32'(fail_addr), 32'd0);
        check_eq("reset.fail_data", 32'(fail_data), 32'd0);
        check_eq("reset.err_cnt",   32'(err_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_bist("ideal", 8'hA5, 1'b0, 0);

        f_and[3] = 8'hFE;
        run_bist("bit0_a3", 8'hA5, 1'b0, 0);
        check_eq("bit0_a3.fail_data_const", 32'(fail_data), 32'h68);

        clear_faults();
        f_and[3] = 8'h00;
        f_and[9] = 8'h00;
        run_bist("stuck_3_9", 8'hA5, 1'b0, 0);

        // Every read returns 0x00; no pattern for seed A5 is 0x00, so all 32 miss.
        for (int i = 0; i < RAM_BYTES; i++) f_and[i] = 8'h00;
        run_bist("saturate", 8'hA5, 1'b0, 0);

        clear_faults();
        run_bist("poke_rd0", 8'h3C, 1'b1, 0);

        run_bist("rst_wr1", 8'h5A, 1'b0, 40);
        run_bist("after_rst", 8'h5A, 1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            clear_faults();
            for (int a = 0; a < RAM_BYTES; a++) begin
                if ($urandom_range(0, 5) == 0) begin
                    f_and[a] = 8'($urandom);
                    f_or[a]  = 8'($urandom);
                end
            end
            run_bist($sformatf("rand%0d", r), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        check_eq("strobe_overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bist_host.md
MEM_BIST_HOST -- requirements
Module: mem_bist_host

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 16: number of memory locations exercised.
REQ-002 SHALL have parameter ADDR_BITS, default 4: memory address width, where RAM_BYTES <= 2**ADDR_BITS.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a test run; sampled only in IDLE.
REQ-006 SHALL have port seed, input, 8: pattern seed; captured at start.
REQ-007 SHALL have port mem_addr, output, ADDR_BITS: address driven to the memory.
REQ-008 SHALL have port mem_wr_en, output, 1: memory write strobe.
REQ-009 SHALL have port mem_r_en, output, 1: memory read strobe.
REQ-010 SHALL have port mem_wdata, output, 8: memory write data.
REQ-011 SHALL have port mem_rdata, input, 8: memory read data, registered by the memory on the edge that samples mem_r_en.
REQ-012 SHALL have port busy, output, 1: a run is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at the end of a run.
REQ-014 SHALL have port pass, output, 1: last run had no mismatches; held until the next start.
REQ-015 SHALL have port fail_addr, output, ADDR_BITS: address of the first mismatch.
REQ-016 SHALL have port fail_data, output, 8: read data at the first mismatch.
REQ-017 SHALL have port err_cnt, output, 5: saturating mismatch count (see Configuration).

Function
REQ-018 SHALL use states IDLE, WR0, RD0, DR0, WR1, RD1, DR1, DONE; transitions IDLE->WR0 on start, WRx->RDx and RDx->DRx after address RAM_BYTES-1, DR0->WR1, DR1->DONE, DONE->IDLE unconditionally.
REQ-019 SHALL define pattern P(a) = seed_q XOR {a[3:0],a[3:0]}; WR0/RD0 use P(a), WR1/RD1 use ~P(a).
REQ-020 SHALL, in WRx, drive mem_wr_en=1, mem_r_en=0, mem_addr=a, mem_wdata=pattern(a), with a = 0..RAM_BYTES-1, one address per cycle.
REQ-021 SHALL, in RDx, drive mem_r_en=1, mem_wr_en=0, mem_addr=a, mem_wdata=0, with a = 0..RAM_BYTES-1, one per cycle.
REQ-022 SHALL compare mem_rdata against the expected pattern for the address read one cycle earlier (pipelined); DRx performs only the final compare with both strobes low.
REQ-023 SHALL never assert mem_wr_en and mem_r_en in the same cycle; in IDLE, DRx and DONE both SHALL be 0.
REQ-024 SHALL, on the first mismatch of a run, capture fail_addr and fail_data and clear pass; later mismatches SHALL NOT overwrite the capture.
REQ-025 SHALL, at start, set pass=1, clear fail_addr, fail_data and err_cnt, and capture seed into seed_q.
REQ-026 SHALL assert busy in every state except IDLE; start while busy SHALL be ignored.
REQ-027 SHALL assert done exactly 4*RAM_BYTES+2 clocks after the edge that sampled start (66 at default), for one cycle.
REQ-028 SHALL wrap the address counter to 0 on each state change.

Reset
REQ-029 SHALL, on rst_n low (any state, including mid-run), immediately force IDLE, all outputs 0, pass=0, and seed_q=0.
REQ-030 SHALL resume normal operation on the first start after rst_n is released.

Configuration
REQ-031 SHALL, with MEM_BIST_ERRCNT_EN defined, increment err_cnt on every mismatch and saturate at 31; without it, err_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Structure
REQ-032 SHALL place the state enumeration, the default ADDR_BITS and the pattern function in package mem_bist_pkg.
REQ-033 SHALL implement the compare, first-fail capture and error counter in sub-module mem_bist_chk.

Verification
REQ-034 SHALL cover: seed=8'hA5 with an ideal 16x8 memory model -> done at +66 cycles, pass=1, err_cnt=0.
REQ-035 SHALL cover: model forces rdata bit0=0 at address 3, seed=8'hA5 -> RD0 clean (P=8'h96); RD1 mismatch; pass=0, fail_addr=3, fail_data=8'h68.
REQ-036 SHALL cover: with MEM_BIST_ERRCNT_EN defined, addresses 3 and 9 stuck at 8'h00 -> err_cnt=4.
REQ-037 SHALL cover: start pulsed during RD0 -> ignored; done still at +66 from the original start.
REQ-038 SHALL cover: rst_n low during WR1 -> same cycle all outputs 0 and strobes low; a new start then completes with pass=1.
REQ-039 SHALL cover: an assertion over all runs that mem_wr_en and mem_r_en are never high together.
